// File: rtl/dut_launcher.sv
// dut_launcher: initiator side of the req/ack program-launch handshake.
// Each start runs NUM_JOBS jobs back to back. Every job preloads a data
// memory window with an LFSR byte pattern, pulses req, and then waits for
// ack while counting cycles.
// Optional watchdog: define DUT_LAUNCHER_TIMEOUT_EN to abort a job whose WAIT
// count reaches TIMEOUT without an ack. With the macro undefined, WAIT has no
// limit, ERR is unreachable and timeout stays 0.
module dut_launcher #(
  parameter int         NUM_JOBS   = 3,
  parameter logic [7:0] LOAD_BASE  = 8'h00,
  parameter int         LOAD_LEN   = 64,
  parameter int         REQ_CYCLES = 2,
  parameter int         TIMEOUT    = 4095,
  parameter int         CNT_W      = 12,
  parameter logic [7:0] SEED       = 8'hA5
) (
  input  logic             clk,
  input  logic             init,
  input  logic             start,
  input  logic             ack,
  output logic             req,
  output logic             mem_wen,
  output logic [7:0]       mem_addr,
  output logic [7:0]       mem_in,
  output logic             busy,
  output logic             done,
  output logic             timeout,
  output logic [3:0]       job_idx,
  output logic [CNT_W-1:0] last_cycles
);

`ifdef DUT_LAUNCHER_TIMEOUT_EN
  localparam bit WDOG_EN = 1'b1;
`else
  localparam bit WDOG_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    REQ,
    WAIT,
    DONE,
    ERR
  } state_t;

  // A zero-length window skips LOAD entirely.
  localparam bit               LEN_ZERO  = (LOAD_LEN == 0);
  localparam logic [8:0]       LOAD_END  = 9'(LOAD_LEN);
  localparam logic [15:0]      REQ_LAST  = 16'(REQ_CYCLES);
  localparam logic [3:0]       LAST_JOB  = 4'(NUM_JOBS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  // A TIMEOUT the saturating counter can never reach disables the abort.
  localparam bit               TO_REACH  = (TIMEOUT >= 1) &&
                                           (longint'(TIMEOUT) <= ((longint'(1) << CNT_W) - 1));
  localparam logic [CNT_W-1:0] TO_VAL    = CNT_W'(TIMEOUT);

  state_t           state;
  logic [7:0]       lfsr;
  logic [8:0]       byte_cnt;
  logic [15:0]      req_cnt;
  logic [CNT_W-1:0] wait_cnt;
  logic             wdog_hit;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // Watchdog fires when the WAIT count sits at TIMEOUT; ack still has priority.
  always_comb begin
    wdog_hit = WDOG_EN && TO_REACH && (wait_cnt == TO_VAL);
  end

  // Launcher sequencer: state, counters, LFSR and every registered output.
  always_ff @(posedge clk or posedge init) begin
    if (init) begin
      state       <= IDLE;
      lfsr        <= SEED;
      byte_cnt    <= '0;
      req_cnt     <= '0;
      wait_cnt    <= '0;
      req         <= 1'b0;
      mem_wen     <= 1'b0;
      mem_addr    <= '0;
      mem_in      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      job_idx     <= '0;
      last_cycles <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (start) begin
            done    <= 1'b0;
            timeout <= 1'b0;
            job_idx <= '0;
            busy    <= 1'b1;
            if (LEN_ZERO) begin
              state   <= REQ;
              lfsr    <= SEED;
              req     <= 1'b1;
              req_cnt <= 16'd1;
            end else begin
              state    <= LOAD;
              mem_wen  <= 1'b1;
              mem_addr <= LOAD_BASE;
              mem_in   <= SEED;
              lfsr     <= lfsr_next(SEED);
              byte_cnt <= 9'd1;
            end
          end
        end

        LOAD: begin
          if (byte_cnt == LOAD_END) begin
            state    <= REQ;
            mem_wen  <= 1'b0;
            mem_addr <= '0;
            mem_in   <= '0;
            req      <= 1'b1;
            req_cnt  <= 16'd1;
          end else begin
            mem_addr <= LOAD_BASE + byte_cnt[7:0];
            mem_in   <= lfsr;
            lfsr     <= lfsr_next(lfsr);
            byte_cnt <= byte_cnt + 9'd1;
          end
        end

        REQ: begin
          if (req_cnt >= REQ_LAST) begin
            state    <= WAIT;
            req      <= 1'b0;
            wait_cnt <= CNT_W'(1);
          end else begin
            req_cnt <= req_cnt + 16'd1;
          end
        end

        WAIT: begin
          if (ack) begin
            last_cycles <= wait_cnt;
            if (job_idx == LAST_JOB) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              job_idx <= job_idx + 4'd1;
              if (LEN_ZERO) begin
                state   <= REQ;
                req     <= 1'b1;
                req_cnt <= 16'd1;
              end else begin
                state    <= LOAD;
                mem_wen  <= 1'b1;
                mem_addr <= LOAD_BASE;
                mem_in   <= lfsr;
                lfsr     <= lfsr_next(lfsr);
                byte_cnt <= 9'd1;
              end
            end
          end else if (wdog_hit) begin
            state   <= ERR;
            busy    <= 1'b0;
            timeout <= 1'b1;
          end else if (wait_cnt != CNT_MAX) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dut_launcher.sv
// tb_dut_launcher: two launcher instances (default parameters, and a wrapped
// 32-byte window with a short TIMEOUT) driven through shared helper tasks.
module tb_dut_launcher;

  localparam int         A_JOBS  = 3;
  localparam int         A_LEN   = 64;
  localparam int         A_REQ   = 2;
  localparam logic [7:0] A_BASE  = 8'h00;
  localparam int         A_TO    = 4095;
  localparam int         B_JOBS  = 2;
  localparam int         B_LEN   = 32;
  localparam int         B_REQ   = 3;
  localparam logic [7:0] B_BASE  = 8'hF0;
  localparam int         B_TO    = 20;
  localparam logic [7:0] SEED    = 8'hA5;
  localparam int         CNT_MAX = 4095;

  typedef struct {
    int sel;
    int w0;
    int w1;
    int w2;
    bit air;
    bit hs;
    int exp_last;
    int exp_idx;
  } vec_t;

  logic clk = 1'b0;
  logic init = 1'b1;
  logic start_x = 1'b0;
  logic ack_x = 1'b0;
  logic sel = 1'b0;

  logic start_a, ack_a, start_b, ack_b;
  logic req_a, mem_wen_a, busy_a, done_a, timeout_a;
  logic req_b, mem_wen_b, busy_b, done_b, timeout_b;
  logic [7:0]  mem_addr_a, mem_in_a, mem_addr_b, mem_in_b;
  logic [3:0]  job_idx_a, job_idx_b;
  logic [11:0] last_cycles_a, last_cycles_b;

  logic req_o, mem_wen_o, busy_o, done_o, timeout_o;
  logic [7:0]  mem_addr_o, mem_in_o;
  logic [3:0]  job_idx_o;
  logic [11:0] last_cycles_o;

  int n_checks = 0;
  int n_pass = 0;
  logic [7:0] m_lfsr;
  int m_last[2];
  logic [7:0] rec_addr[3];
  logic [7:0] rec_data[3];
  logic [7:0] a15, a16;
  vec_t vecs[5];

  always #5 clk = ~clk;

  assign start_a = start_x & ~sel;
  assign ack_a   = ack_x & ~sel;
  assign start_b = start_x & sel;
  assign ack_b   = ack_x & sel;

  assign req_o         = sel ? req_b : req_a;
  assign mem_wen_o     = sel ? mem_wen_b : mem_wen_a;
  assign busy_o        = sel ? busy_b : busy_a;
  assign done_o        = sel ? done_b : done_a;
  assign timeout_o     = sel ? timeout_b : timeout_a;
  assign mem_addr_o    = sel ? mem_addr_b : mem_addr_a;
  assign mem_in_o      = sel ? mem_in_b : mem_in_a;
  assign job_idx_o     = sel ? job_idx_b : job_idx_a;
  assign last_cycles_o = sel ? last_cycles_b : last_cycles_a;

  dut_launcher u_a (
    .clk(clk), .init(init), .start(start_a), .ack(ack_a),
    .req(req_a), .mem_wen(mem_wen_a), .mem_addr(mem_addr_a), .mem_in(mem_in_a),
    .busy(busy_a), .done(done_a), .timeout(timeout_a),
    .job_idx(job_idx_a), .last_cycles(last_cycles_a)
  );

  dut_launcher #(
    .NUM_JOBS(B_JOBS), .LOAD_BASE(B_BASE), .LOAD_LEN(B_LEN),
    .REQ_CYCLES(B_REQ), .TIMEOUT(B_TO)
  ) u_b (
    .clk(clk), .init(init), .start(start_b), .ack(ack_b),
    .req(req_b), .mem_wen(mem_wen_b), .mem_addr(mem_addr_b), .mem_in(mem_in_b),
    .busy(busy_b), .done(done_b), .timeout(timeout_b),
    .job_idx(job_idx_b), .last_cycles(last_cycles_b)
  );

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  function automatic int sat(input int w);
    return (w > CNT_MAX) ? CNT_MAX : w;
  endfunction

  function automatic int cur_len();
    return sel ? B_LEN : A_LEN;
  endfunction

  function automatic int cur_req();
    return sel ? B_REQ : A_REQ;
  endfunction

  function automatic int cur_jobs();
    return sel ? B_JOBS : A_JOBS;
  endfunction

  function automatic int cur_base();
    return sel ? int'(B_BASE) : int'(A_BASE);
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Pulse start for one cycle and reseed the reference LFSR.
  task automatic startRun();
    start_x = 1'b1;
    tick();
    start_x = 1'b0;
    m_lfsr = SEED;
    checkOutput("start_busy", busy_o, 1);
    checkOutput("start_flags", {done_o, timeout_o}, 0);
    checkOutput("start_job_idx", job_idx_o, 0);
  endtask

  // Follow the preload and req phases of one job against the reference.
  task automatic loadReq(input bit air, input int job);
    int n_load;
    int n_req;
    int bad;
    logic [7:0] ea;
    n_load = 0;
    n_req = 0;
    bad = 0;
    while (mem_wen_o === 1'b1 && n_load < 300) begin
      ea = 8'(cur_base() + n_load);
      if (mem_addr_o !== ea || mem_in_o !== m_lfsr || busy_o !== 1'b1 || req_o !== 1'b0) bad++;
      if (job == 0 && n_load < 3) begin
        rec_addr[n_load] = mem_addr_o;
        rec_data[n_load] = mem_in_o;
      end
      if (sel && n_load == 15) a15 = mem_addr_o;
      if (sel && n_load == 16) a16 = mem_addr_o;
      m_lfsr = lfsr_step(m_lfsr);
      n_load++;
      tick();
    end
    checkOutput("load_len", n_load, cur_len());
    checkOutput("load_bytes", bad, 0);
    bad = 0;
    while (req_o === 1'b1 && n_req < 20) begin
      if (mem_wen_o !== 1'b0 || busy_o !== 1'b1) bad++;
      ack_x = air;
      n_req++;
      tick();
    end
    ack_x = 1'b0;
    checkOutput("req_len", n_req, cur_req());
    checkOutput("req_bus", bad, 0);
  endtask

  // Sit in WAIT for w cycles, acking on the w-th, optionally holding start.
  task automatic waitAck(input int w, input bit hs, input int job);
    int bad;
    bad = 0;
    for (int k = 1; k <= w; k++) begin
      if (busy_o !== 1'b1 || req_o !== 1'b0 || mem_wen_o !== 1'b0 ||
          timeout_o !== 1'b0 || done_o !== 1'b0 || job_idx_o !== 4'(job)) bad++;
      start_x = hs && (k < w);
      ack_x = (k == w);
      tick();
    end
    start_x = 1'b0;
    ack_x = 1'b0;
    checkOutput("wait_state", bad, 0);
    checkOutput("last_cycles", last_cycles_o, sat(w));
    m_last[sel] = sat(w);
  endtask

  // One complete run on the selected instance.
  task automatic applyStimulus(input int s, input int w0, input int w1, input int w2,
                               input bit air, input bit hs, output int last_o, output int idx_o);
    int ws[3];
    ws[0] = w0;
    ws[1] = w1;
    ws[2] = w2;
    sel = s[0];
    startRun();
    for (int j = 0; j < cur_jobs(); j++) begin
      checkOutput("job_idx", job_idx_o, j);
      loadReq(air, j);
      waitAck(ws[j], hs, j);
    end
    checkOutput("end_done_busy", {done_o, busy_o}, 2'b10);
    last_o = int'(last_cycles_o);
    idx_o = int'(job_idx_o);
  endtask

  initial begin
    int last, idx, w_big, bad;

    vecs[0] = '{sel: 0, w0: 5,  w1: 5, w2: 5,  air: 0, hs: 0, exp_last: 5,  exp_idx: 2};
    vecs[1] = '{sel: 0, w0: 1,  w1: 7, w2: 3,  air: 1, hs: 0, exp_last: 3,  exp_idx: 2};
    vecs[2] = '{sel: 0, w0: 2,  w1: 9, w2: 12, air: 0, hs: 1, exp_last: 12, exp_idx: 2};
    vecs[3] = '{sel: 1, w0: 20, w1: 4, w2: 0,  air: 0, hs: 0, exp_last: 4,  exp_idx: 1};
    vecs[4] = '{sel: 1, w0: 1,  w1: 1, w2: 0,  air: 1, hs: 1, exp_last: 1,  exp_idx: 1};
    m_last[0] = 0;
    m_last[1] = 0;

    tick();
    tick();
    checkOutput("reset_a", {req_a, mem_wen_a, busy_a, done_a, timeout_a, mem_addr_a, mem_in_a, job_idx_a}, 0);
    checkOutput("reset_b", {req_b, mem_wen_b, busy_b, done_b, timeout_b, mem_addr_b, mem_in_b, job_idx_b}, 0);
    checkOutput("reset_last", {last_cycles_a, last_cycles_b}, 0);
    init = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i].sel, vecs[i].w0, vecs[i].w1, vecs[i].w2, vecs[i].air, vecs[i].hs, last, idx);
      checkOutput("vec_last", last, vecs[i].exp_last);
      checkOutput("vec_idx", idx, vecs[i].exp_idx);
      if (i == 0) begin
        checkOutput("first_bytes_addr", {rec_addr[0], rec_addr[1], rec_addr[2]}, 24'h000102);
        checkOutput("first_bytes_data", {rec_data[0], rec_data[1], rec_data[2]}, 24'hA54A95);
      end
    end
    checkOutput("wrap_ff", a15, 8'hFF);
    checkOutput("wrap_00", a16, 8'h00);

    for (int r = 0; r < 6; r++) begin
      int s, jobs, to;
      int w[3];
      bit air, hs;
      s = int'($urandom_range(0, 1));
      to = s ? B_TO : 40;
      for (int j = 0; j < 3; j++) w[j] = int'($urandom_range(1, to));
      air = 1'($urandom_range(0, 1));
      hs = 1'($urandom_range(0, 1));
      jobs = s ? B_JOBS : A_JOBS;
      applyStimulus(s, w[0], w[1], w[2], air, hs, last, idx);
      checkOutput("rand_last", last, sat(w[jobs - 1]));
      checkOutput("rand_idx", idx, jobs - 1);
    end

`ifdef DUT_LAUNCHER_TIMEOUT_EN
    w_big = A_TO;
`else
    w_big = A_TO + 5;
`endif
    applyStimulus(0, 1, 2, w_big, 0, 0, last, idx);
    checkOutput("sat_last", last, CNT_MAX);

    sel = 1'b1;
    startRun();
    loadReq(1'b0, 0);
`ifdef DUT_LAUNCHER_TIMEOUT_EN
    bad = 0;
    for (int k = 1; k <= B_TO; k++) begin
      if (busy_o !== 1'b1 || timeout_o !== 1'b0) bad++;
      tick();
    end
    checkOutput("wdog_wait", bad, 0);
    checkOutput("wdog_timeout", timeout_o, 1);
    checkOutput("wdog_busy_done", {busy_o, done_o}, 0);
    checkOutput("wdog_job", job_idx_o, 0);
    checkOutput("wdog_last", last_cycles_o, m_last[1]);
    applyStimulus(1, 2, 3, 0, 0, 0, last, idx);
    checkOutput("restart_seed", {rec_addr[0], rec_data[0]}, {B_BASE, SEED});
    checkOutput("restart_last", last, 3);
`else
    waitAck(2 * B_TO, 1'b0, 0);
    loadReq(1'b0, 1);
    waitAck(2, 1'b0, 1);
    checkOutput("nolimit_done", {done_o, busy_o, timeout_o}, 3'b100);
`endif

    sel = 1'b0;
    startRun();
    repeat (5) tick();
    #2 init = 1'b1;
    #1;
    checkOutput("async_reset_a", {req_a, mem_wen_a, busy_a, done_a, timeout_a, mem_addr_a, mem_in_a, job_idx_a}, 0);
    checkOutput("async_reset_last", {last_cycles_a, last_cycles_b}, 0);
    m_last[0] = 0;
    m_last[1] = 0;
    tick();
    init = 1'b0;
    tick();
    applyStimulus(0, 4, 4, 4, 0, 0, last, idx);
    checkOutput("post_reset_seed", {rec_addr[0], rec_data[0]}, {A_BASE, SEED});
    checkOutput("post_reset_last", last, 4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dut_launcher.md
# dut_launcher

Initiator side of the req/ack program-launch handshake. On `start` it runs `NUM_JOBS` jobs back to back; each job has three steps. First it preloads a data memory window with an LFSR byte pattern through the memory write port. Next it drives `req` to launch the program. Last it waits for `ack` and records the cycle count. A watchdog aborts a job that never acknowledges. The block sits in the test harness, between the stimulus controller and the DUT top level, and shares the DUT's `DataMem` write port while the DUT is idle.

## Interface
Parameters:
- `NUM_JOBS`, 3: jobs per `start`, range 1..15.
- `LOAD_BASE`, 8'h00: first preload address.
- `LOAD_LEN`, 64: bytes written per job, range 0..256.
- `REQ_CYCLES`, 2: `req` high time in cycles, minimum 1.
- `TIMEOUT`, 4095: WAIT-cycle limit before abort.
- `CNT_W`, 12: width of the cycle counter.
- `SEED`, 8'hA5: LFSR reset and reseed value, nonzero.

Ports:
- `clk` in 1: clock; all state changes on the rising edge.
- `init` in 1: reset, asynchronous and active-high.
- `start` in 1: begin a run; sampled only in IDLE, DONE or ERR.
- `ack` in 1: DUT completion flag.
- `req` out 1: program launch request to the DUT.
- `mem_wen` out 1: data memory write enable.
- `mem_addr` out 8: data memory address.
- `mem_in` out 8: data memory write data.
- `busy` out 1: a run is in progress.
- `done` out 1: all jobs completed.
- `timeout` out 1: a run aborted on the watchdog.
- `job_idx` out 4: index of the current or last job.
- `last_cycles` out CNT_W: WAIT length of the last completed job.

## Operation
- States: IDLE, LOAD, REQ, WAIT, DONE, ERR.
- Reset (`init`=1, any time, including mid-run):
  - state goes to IDLE.
  - All outputs go to 0.
  - LFSR goes to `SEED`.
  - `job_idx`, `last_cycles` and internal counters go to 0.
- IDLE, DONE or ERR with `start`=1:
  - clear `done`, `timeout` and `job_idx`.
  - Reseed the LFSR to `SEED`.
  - Go to LOAD. If `LOAD_LEN`=0, go straight to REQ.
- LOAD:
  - Each cycle: `mem_wen`=1, `mem_addr` = (`LOAD_BASE`+i) mod 256, `mem_in` = LFSR, where i is the byte index 0..`LOAD_LEN`-1.
  - The LFSR advances after each byte.
  - The address wraps 8'hFF→8'h00 with no error.
  - After byte `LOAD_LEN`-1, go to REQ.
- LFSR: next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}. The sequence continues across jobs within a run; it is not reseeded per job.
- REQ:
  - `req`=1 for exactly `REQ_CYCLES` cycles, then go to WAIT.
  - `ack` is ignored in this state.
- WAIT:
  - `req`=0.
  - The cycle counter counts 1 on the first WAIT cycle and saturates at 2^CNT_W-1.
  - `ack`=1 in WAIT: latch the count into `last_cycles`.
    - If `job_idx`=`NUM_JOBS`-1, go to DONE.
    - Otherwise increment `job_idx` and go to LOAD (or REQ if `LOAD_LEN`=0).
  - Count = `TIMEOUT` with `ack`=0: go to ERR. `last_cycles` keeps its prior value.
  - If `ack` and the timeout occur in the same cycle, `ack` wins.
- DONE: `done`=1 until the next `start` or `init`.
- ERR: `timeout`=1 until the next `start` or `init`; `job_idx` shows the failing job.
- `start` in LOAD, REQ or WAIT is ignored.
- `busy`=1 exactly in LOAD, REQ and WAIT.
- `mem_wen`=0 outside LOAD, so the DUT owns the memory during REQ and WAIT.

## Timing
- All outputs are registered; state transitions take effect on the edge after the qualifying input is sampled.
- `start` sampled at edge 0: `busy` and the first `mem_wen` appear after edge 0.
- Per-job cycle count = `LOAD_LEN` + `REQ_CYCLES` + W, where W is the WAIT cycle in which `ack` is sampled.
  - Example, defaults with W=5: 71 cycles; `done` rises after the third job's `ack` edge.
- `req` drops in the same cycle that WAIT begins.
- `ack` must be sampled high for at least one cycle in WAIT; a single-cycle pulse is sufficient.

## Configuration
- `DUT_LAUNCHER_TIMEOUT_EN` defined: the watchdog is present as described.
- `DUT_LAUNCHER_TIMEOUT_EN` undefined:
  - WAIT has no limit and ERR is unreachable.
  - `timeout` is tied to 0.
  - The counter still saturates and `last_cycles` still reports it.

## Test plan
- Reset then `start` with defaults: writes to 8'h00, 8'h01, 8'h02 carry data A5, 4A, 95. 64 writes occur, then `req` is high for 2 cycles.
- `ack` pulsed on WAIT cycle 5 for each of 3 jobs: `last_cycles`=5, `job_idx` ends at 2, `done`=1, `busy`=0. Job 2 preload continues the LFSR, with no reseed to A5.
- `LOAD_BASE`=8'hF0 with `LOAD_LEN`=32: addresses run F0..FF then 00..0F.
- `ack` never asserted, `TIMEOUT`=20 (macro defined): `timeout`=1 after 20 WAIT cycles with `job_idx`=0. A following `start` clears it and restarts from seed A5.
- `ack` held high during REQ, then low: no job completion. `ack` arriving on the cycle count equals `TIMEOUT` → job completes and `timeout` stays 0.
- `init` asserted mid-LOAD, asynchronously between edges: all outputs go to 0 immediately. `start` held during WAIT is ignored.
